// File: rtl/mem_bist_engine.sv
// mem_bist_engine: Wishbone-master memory self-test (word/half/byte sweeps).
// Optional bus watchdog: define MEM_BIST_TIMEOUT_EN.
// Ports: sys_clk/sys_rst, start/busy/done/pass, err_addr/err_timeout,
//   checkbits status code, Wishbone master wb_* (word address on wb_adr_o).
module mem_bist_engine #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [2:0]  MODES       = 3'b111,
  parameter logic [31:0] SEED        = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] err_addr,
  output logic        err_timeout,
  output logic [15:0] checkbits,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [29:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WRITE, S_READ,
    S_NEXT, S_PASS, S_FAIL
  } state_t;

  localparam logic [31:0] DB = 32'(DEPTH_BYTES);

  state_t      r_state, w_state;
  logic [2:0]  r_mode, w_mode;
  logic [31:0] r_idx, w_idx;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_pass, w_pass;
  logic [31:0] r_err_addr, w_err_addr;
  logic        r_err_to, w_err_to;
  logic [15:0] r_cb, w_cb;
  logic        r_cyc, w_cyc;
  logic        r_we, w_we;
  logic [29:0] r_adr, w_adr;
  logic [31:0] r_dat, w_dat;
  logic [3:0]  r_sel, w_sel;

  logic [1:0]  w_shift;
  logic [31:0] w_addr;
  logic [31:0] w_pat;
  logic [31:0] w_dat_x;
  logic [3:0]  w_sel_x;
  logic [31:0] w_lmask;
  logic        w_last;
  logic        w_miss;
  logic        w_tout;
  logic [2:0]  w_nmode;

  // Next enabled mode strictly after cur in word->half->byte order.
  function automatic logic [2:0] f_next(input logic [2:0] cur);
    logic [2:0] m;
    m = MODES;
    if (cur[2]) m = MODES & 3'b011;
    else if (cur[1]) m = MODES & 3'b001;
    else if (cur[0]) m = 3'b000;
    if (m[2]) return 3'b100;
    if (m[1]) return 3'b010;
    if (m[0]) return 3'b001;
    return 3'b000;
  endfunction

  assign w_shift = r_mode[2] ? 2'd2 :
                   r_mode[1] ? 2'd1 : 2'd0;
  assign w_addr  = BASE_ADDR + (r_idx << w_shift);
  assign w_pat   = SEED ^ {~r_idx[15:0], r_idx[15:0]};
  assign w_last  = (r_idx == ((DB >> w_shift) - 32'd1));
  assign w_nmode = f_next(r_mode);

  always_comb begin
    w_dat_x = {4{w_pat[7:0]}};
    w_sel_x = 4'b0001 << w_addr[1:0];
    unique case (1'b1)
      r_mode[2]: begin
        w_dat_x = w_pat;
        w_sel_x = 4'b1111;
      end
      r_mode[1]: begin
        w_dat_x = {2{w_pat[15:0]}};
        w_sel_x = w_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Only lanes enabled for the current access take part in the compare.
  assign w_lmask = {{8{r_sel[3]}}, {8{r_sel[2]}},
                    {8{r_sel[1]}}, {8{r_sel[0]}}};
  assign w_miss  = |((wb_dat_i ^ r_dat) & w_lmask);

`ifdef MEM_BIST_TIMEOUT_EN
  logic [7:0] r_wdog;

  assign w_tout = r_cyc && !wb_ack_i &&
                  (r_wdog == TIMEOUT_CYC - 8'd1);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !r_cyc || wb_ack_i) r_wdog <= 8'd0;
    else r_wdog <= r_wdog + 8'd1;
  end
`else
  assign w_tout = 1'b0;
`endif

  always_comb begin
    w_state    = r_state;
    w_mode     = r_mode;
    w_idx      = r_idx;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_pass     = r_pass;
    w_err_addr = r_err_addr;
    w_err_to   = r_err_to;
    w_cb       = r_cb;
    w_cyc      = r_cyc;
    w_we       = r_we;
    w_adr      = r_adr;
    w_dat      = r_dat;
    w_sel      = r_sel;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state    = S_NEXT;
          w_mode     = 3'b000;
          w_busy     = 1'b1;
          w_pass     = 1'b0;
          w_err_addr = 32'd0;
          w_err_to   = 1'b0;
        end
      end
      S_NEXT: begin
        if (w_nmode != 3'b000) begin
          w_state = S_START;
          w_mode  = w_nmode;
          w_cb    = {8'hA0, 1'b0, w_nmode, 4'h0};
        end else begin
          w_state = S_PASS;
          w_pass  = 1'b1;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          if (r_mode == 3'b000) w_cb = 16'hAB01;
        end
      end
      S_START: begin
        w_state = S_WRITE;
        w_idx   = 32'd0;
      end
      S_WRITE, S_READ: begin
        if (!r_cyc) begin
          w_cyc = 1'b1;
          w_we  = (r_state == S_WRITE);
          w_adr = w_addr[31:2];
          w_dat = w_dat_x;
          w_sel = w_sel_x;
        end else if (wb_ack_i || w_tout) begin
          w_cyc = 1'b0;
          w_we  = 1'b0;
          if (w_tout || (r_state == S_READ && w_miss)) begin
            w_state    = S_FAIL;
            w_cb       = {8'hAB, 1'b0, r_mode, 4'h0};
            w_err_addr = w_addr;
            w_err_to   = w_tout;
            w_done     = 1'b1;
            w_busy     = 1'b0;
          end else if (!w_last) begin
            w_idx = r_idx + 32'd1;
          end else if (r_state == S_WRITE) begin
            w_state = S_READ;
            w_idx   = 32'd0;
          end else begin
            w_state = S_NEXT;
            w_cb    = {8'hAB, 1'b0, r_mode, 4'h1};
          end
        end
      end
      S_PASS, S_FAIL: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 3'b000;
      r_idx      <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_addr <= 32'd0;
      r_err_to   <= 1'b0;
      r_cb       <= 16'h0000;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= 30'd0;
      r_dat      <= 32'd0;
      r_sel      <= 4'b0000;
    end else begin
      r_state    <= w_state;
      r_mode     <= w_mode;
      r_idx      <= w_idx;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_pass     <= w_pass;
      r_err_addr <= w_err_addr;
      r_err_to   <= w_err_to;
      r_cb       <= w_cb;
      r_cyc      <= w_cyc;
      r_we       <= w_we;
      r_adr      <= w_adr;
      r_dat      <= w_dat;
      r_sel      <= w_sel;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_addr    = r_err_addr;
  assign err_timeout = r_err_to;
  assign checkbits   = r_cb;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;
  assign wb_we_o     = r_we;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat;
  assign wb_sel_o    = r_sel;

endmodule
